// File: rtl/sqrt2_pkg.sv
// Shared types and constants for the sqrt2 core arbiter.
package sqrt2_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [15:0] FP16_QNAN = 16'hFE00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  // Requester ID width; never collapses to zero bits.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt2_arbiter_if.sv
// Client-side request/response bundle between the requesters and the arbiter.
interface sqrt2_arbiter_if
  import sqrt2_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int IDW = id_w(N_REQ);

  // Handshakes: REQ_VALID[i]/REQ_DATA slice i stay stable until the one-cycle
  // REQ_READY[i] pulse; RSP_VALID and all RSP_* stay stable until the cycle
  // in which RSP_VALID && RSP_READY, which completes the transfer.
  logic [N_REQ-1:0]    REQ_VALID;
  logic [16*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]    REQ_READY;
  logic                RSP_VALID;
  logic                RSP_READY;
  logic [IDW-1:0]      RSP_ID;
  logic [15:0]         RSP_DATA;
  logic                RSP_NAN;
  logic                RSP_PINF;
  logic                RSP_NINF;
  logic                RSP_TIMEOUT;

  modport master (
    output REQ_VALID, REQ_DATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_ID, RSP_DATA,
    input  RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_ID, RSP_DATA,
    output RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT
  );

endinterface

// File: rtl/sqrt2_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import sqrt2_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDW-1:0]   gnt_idx,
  output logic             gnt_any
);

  int cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!gnt_any && req[cand]) begin
        gnt_any      = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/sqrt2_arbiter.sv
// Shares one sqrt2 FP16 square-root core between N_REQ requesters, one
// operation in flight, round-robin grant, tagged result with timeout abort.
module sqrt2_arbiter
  import sqrt2_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 100,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  sqrt2_arbiter_if.slave   bus,
  inout  wire  [15:0]      CORE_IO,
  output logic             CORE_ENABLE,
  input  logic             CORE_RESULT,
  input  logic             CORE_NAN,
  input  logic             CORE_PINF,
  input  logic             CORE_NINF,
  output state_t           dbg_state
);

  localparam int IDW   = id_w(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + LOAD_CYCLES + GAP_CYCLES + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [15:0]      op_q, op_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             rsp_nan_q, rsp_nan_d;
  logic             rsp_pinf_q, rsp_pinf_d;
  logic             rsp_ninf_q, rsp_ninf_d;
  logic             rsp_to_q, rsp_to_d;

  logic [N_REQ-1:0] gnt_oh;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [15:0]      gnt_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req     (bus.REQ_VALID),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) gnt_data = bus.REQ_DATA[16*i +: 16];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ready_d    = '0;
    op_d       = op_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_nan_d  = rsp_nan_q;
    rsp_pinf_d = rsp_pinf_q;
    rsp_ninf_d = rsp_ninf_q;
    rsp_to_d   = rsp_to_q;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ready_d = gnt_oh;
          op_d    = gnt_data;
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        // A RESULT arriving on the last allowed cycle still wins over the abort.
        if (CORE_RESULT) begin
          rsp_data_d = CORE_IO;
          rsp_nan_d  = CORE_NAN;
          rsp_pinf_d = CORE_PINF;
          rsp_ninf_d = CORE_NINF;
          rsp_to_d   = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d = FP16_QNAN;
          rsp_nan_d  = 1'b1;
          rsp_pinf_d = 1'b0;
          rsp_ninf_d = 1'b0;
          rsp_to_d   = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.RSP_READY) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      ready_q    <= '0;
      op_q       <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_nan_q  <= 1'b0;
      rsp_pinf_q <= 1'b0;
      rsp_ninf_q <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ready_q    <= ready_d;
      op_q       <= op_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_nan_q  <= rsp_nan_d;
      rsp_pinf_q <= rsp_pinf_d;
      rsp_ninf_q <= rsp_ninf_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  // The bus is ours only in LOAD; the core may drive it from WAIT onward.
  assign CORE_IO     = (state_q == LOAD) ? op_q : 16'hzzzz;
  assign CORE_ENABLE = (state_q == LOAD) || (state_q == WAIT) || (state_q == RESP);

  assign bus.REQ_READY   = ready_q;
  assign bus.RSP_VALID   = (state_q == RESP);
  assign bus.RSP_ID      = id_q;
  assign bus.RSP_DATA    = rsp_data_q;
  assign bus.RSP_NAN     = rsp_nan_q;
  assign bus.RSP_PINF    = rsp_pinf_q;
  assign bus.RSP_NINF    = rsp_ninf_q;
  assign bus.RSP_TIMEOUT = rsp_to_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_sqrt2_arbiter.sv
// Bench for sqrt2_arbiter with a behavioural sqrt2 core model on the tri-state bus.
module tb_sqrt2_arbiter;
  import sqrt2_pkg::*;

  localparam int N_REQ       = 4;
  localparam int LOAD_CYCLES = 2;
  localparam int TIMEOUT     = 100;
  localparam int GAP_CYCLES  = 2;
  localparam int CORE_LAT    = 3;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   stub_core = 1'b0;
  wire [15:0] core_io;
  logic   core_en;
  logic   core_res;
  logic   core_drv;
  logic [15:0] core_out;
  logic [15:0] core_op;
  logic [2:0]  core_flags;
  int     core_cnt;
  state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  sqrt2_arbiter_if #(.N_REQ(N_REQ)) bus ();

  sqrt2_arbiter #(
    .N_REQ       (N_REQ),
    .LOAD_CYCLES (LOAD_CYCLES),
    .TIMEOUT     (TIMEOUT),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .bus         (bus),
    .CORE_IO     (core_io),
    .CORE_ENABLE (core_en),
    .CORE_RESULT (core_res),
    .CORE_NAN    (core_flags[2]),
    .CORE_PINF   (core_flags[1]),
    .CORE_NINF   (core_flags[0]),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- sqrt2 core model ----------------
  function automatic logic [18:0] core_fn(input logic [15:0] x);
    case (x)
      16'h3C00: core_fn = {3'b000, 16'h3C00};
      16'h4400: core_fn = {3'b000, 16'h4000};
      16'h4C00: core_fn = {3'b000, 16'h4400};
      16'h5400: core_fn = {3'b000, 16'h4800};
      16'h7C00: core_fn = {3'b010, 16'h7C00};
      16'h8000: core_fn = {3'b000, 16'h8000};
      default:  core_fn = {3'b100, 16'hFE00};
    endcase
  endfunction

  assign core_io = core_drv ? core_out : 16'hzzzz;

  always @(posedge clk) begin
    if (rst || !core_en) begin
      core_cnt   <= 0;
      core_drv   <= 1'b0;
      core_res   <= 1'b0;
      core_flags <= 3'b000;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt < LOAD_CYCLES) core_op <= core_io;
      if (!stub_core && core_cnt == LOAD_CYCLES + CORE_LAT - 1) begin
        core_drv                 <= 1'b1;
        core_res                 <= 1'b1;
        {core_flags, core_out}   <= core_fn(core_op);
      end
    end
  end

  // ---------------- requester driver ----------------
  logic [15:0] lane_mem [N_REQ][16];
  int lane_wr [N_REQ];
  int lane_rd [N_REQ];
  int ready_cnt [N_REQ];
  int grant_log [64];
  int n_grants = 0;

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      lane_wr[i] = 0;
      lane_rd[i] = 0;
      ready_cnt[i] = 0;
    end
    bus.REQ_VALID = '0;
    bus.REQ_DATA  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.REQ_READY[i]) begin
          ready_cnt[i] = ready_cnt[i] + 1;
          grant_log[n_grants % 64] = i;
          n_grants = n_grants + 1;
          if (lane_rd[i] != lane_wr[i]) lane_rd[i] = lane_rd[i] + 1;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        bus.REQ_VALID[i] = (lane_rd[i] != lane_wr[i]);
        bus.REQ_DATA[16*i +: 16] = lane_mem[i][lane_rd[i] % 16];
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [21:0] got_mem [64];
  int n_got = 0;

  always @(negedge clk) begin
    if (!rst && bus.RSP_VALID && bus.RSP_READY) begin
      got_mem[n_got % 64] <= {bus.RSP_TIMEOUT, bus.RSP_NAN, bus.RSP_PINF, bus.RSP_NINF,
                              bus.RSP_ID, bus.RSP_DATA};
      n_got <= n_got + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q [$];
  int got_rd = 0;

  function automatic logic [21:0] pack(input logic to, input logic [2:0] fl,
                                        input logic [1:0] id, input logic [15:0] d);
    return {to, fl, id, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input int lane, input logic [15:0] d);
    lane_mem[lane][lane_wr[lane] % 16] = d;
    lane_wr[lane] = lane_wr[lane] + 1;
  endtask

  task automatic drain(input int n);
    int budget;
    budget = 0;
    while ((n_got - got_rd) < n && budget < 3000) begin
      tick();
      budget++;
    end
    for (int k = 0; k < n; k++) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      if (got_rd < n_got) begin
        check("rsp", {10'd0, got_mem[got_rd % 64]}, {10'd0, e});
        got_rd++;
      end else begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_missing: got none expected %h", e);
      end
    end
  endtask

  typedef struct {
    int          lane;
    logic [15:0] op;
    logic [15:0] exp_data;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int rc;
    int g0;
    int cyc;
    int budget;

    vecs[0] = '{0, 16'h4400, 16'h4000, 3'b000};
    vecs[1] = '{1, 16'hBC00, 16'hFE00, 3'b100};
    vecs[2] = '{2, 16'h7C00, 16'h7C00, 3'b010};
    vecs[3] = '{0, 16'h3C00, 16'h3C00, 3'b000};
    vecs[4] = '{3, 16'h8000, 16'h8000, 3'b000};

    bus.RSP_READY = 1'b1;
    rst = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_state",  32'(dbg_state), 32'(IDLE));
    check("rst_enable", 32'(core_en), 32'd0);
    check("rst_rsp",    {9'd0, bus.RSP_VALID, bus.RSP_TIMEOUT, bus.RSP_NAN, bus.RSP_PINF,
                         bus.RSP_NINF, bus.RSP_ID, bus.RSP_DATA}, 32'd0);
    check("rst_ready",  32'(bus.REQ_READY), 32'd0);
    rst = 1'b0;
    tick();

    // Single operations, including special operands
    for (int v = 0; v < 5; v++) begin
      rc = ready_cnt[vecs[v].lane];
      push_req(vecs[v].lane, vecs[v].op);
      exp_q.push_back(pack(1'b0, vecs[v].exp_flags, 2'(vecs[v].lane), vecs[v].exp_data));
      drain(1);
      check("single_ready_pulses", 32'(ready_cnt[vecs[v].lane] - rc), 32'd1);
    end

    // Same-cycle requests on lanes 0..2; pointer is back at 0
    g0 = n_grants;
    rc = ready_cnt[0] + ready_cnt[1] + ready_cnt[2];
    push_req(0, 16'h3C00);
    push_req(1, 16'h4C00);
    push_req(2, 16'h5400);
    exp_q.push_back(pack(1'b0, 3'b000, 2'd0, 16'h3C00));
    exp_q.push_back(pack(1'b0, 3'b000, 2'd1, 16'h4400));
    exp_q.push_back(pack(1'b0, 3'b000, 2'd2, 16'h4800));
    drain(3);
    check("same_cycle_pulses", 32'(ready_cnt[0] + ready_cnt[1] + ready_cnt[2] - rc), 32'd3);
    check("same_cycle_grants", 32'(n_grants - g0), 32'd3);

    // Fairness: lanes 0 and 1 continuously valid
    g0 = n_grants;
    for (int k = 0; k < 4; k++) begin
      push_req(0, 16'h4400);
      push_req(1, 16'h4C00);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(pack(1'b0, 3'b000, 2'd0, 16'h4000));
      exp_q.push_back(pack(1'b0, 3'b000, 2'd1, 16'h4400));
    end
    drain(8);
    for (int k = 0; k < 8; k++) begin
      check("rr_grant_order", 32'(grant_log[(g0 + k) % 64]), 32'(k % 2));
    end

    // Backpressure: pointer now at 2, so lane 2 wins over lane 3
    bus.RSP_READY = 1'b0;
    push_req(2, 16'h4400);
    push_req(3, 16'h3C00);
    exp_q.push_back(pack(1'b0, 3'b000, 2'd2, 16'h4000));
    exp_q.push_back(pack(1'b0, 3'b000, 2'd3, 16'h3C00));
    budget = 0;
    while (!bus.RSP_VALID && budget < 300) begin
      tick();
      budget++;
    end
    check("bp_rsp_seen", 32'(bus.RSP_VALID), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_hold", {8'd0, bus.RSP_VALID, core_en, bus.REQ_READY, bus.RSP_ID, bus.RSP_DATA},
            {8'd0, 1'b1, 1'b1, 4'b0000, 2'd2, 16'h4000});
    end
    bus.RSP_READY = 1'b1;
    drain(2);

    // Stub core: RESULT never rises, pointer back at 0
    stub_core = 1'b1;
    push_req(0, 16'h4400);
    exp_q.push_back(pack(1'b1, 3'b100, 2'd0, 16'hFE00));
    budget = 0;
    while (bus.REQ_READY == '0 && budget < 100) begin
      tick();
      budget++;
    end
    cyc = 0;
    while (!bus.RSP_VALID && cyc < 400) begin
      tick();
      cyc++;
    end
    check("timeout_latency", 32'(cyc), 32'(LOAD_CYCLES + TIMEOUT));
    drain(1);

    // Reset while waiting on the stub core: operation is dropped
    push_req(1, 16'h4400);
    budget = 0;
    while (bus.REQ_READY == '0 && budget < 100) begin
      tick();
      budget++;
    end
    repeat (5) tick();
    check("mid_wait_state", 32'(dbg_state), 32'(WAIT));
    rst = 1'b1;
    tick();
    check("reset_abort", {28'd0, core_en, bus.RSP_VALID, 2'd0}, 32'd0);
    check("reset_abort_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    stub_core = 1'b0;
    repeat (20) tick();
    check("dropped_result", 32'(n_got - got_rd), 32'd0);

    // Pointer reset to 0: lane 0 beats lane 3
    push_req(3, 16'h4C00);
    push_req(0, 16'h3C00);
    exp_q.push_back(pack(1'b0, 3'b000, 2'd0, 16'h3C00));
    exp_q.push_back(pack(1'b0, 3'b000, 2'd3, 16'h4400));
    drain(2);

    repeat (10) tick();
    check("no_extra_rsp", 32'(n_got - got_rd), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
